// File: rtl/data_type_pkg.sv
// Shared types and constants for the bf16 operation scheduler.
package data_type_pkg;

  localparam int MODE_WIDTH = 3;
  localparam int DATA_WIDTH = 16;

  // Opcodes understood by the shared datapath; codes 4..7 are undefined.
  localparam logic [MODE_WIDTH-1:0] MODE_ADD = 3'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_SUB = 3'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_MUL = 3'd2;
  localparam logic [MODE_WIDTH-1:0] MODE_DIV = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // True for opcodes the datapath implements.
  function automatic logic mode_known(input logic [MODE_WIDTH-1:0] mode);
    return (mode == MODE_ADD) || (mode == MODE_SUB) ||
           (mode == MODE_MUL) || (mode == MODE_DIV);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer picks the winner on contention.
module rr_arb2 (
  input  logic       en_i,
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // Grant the lone requester, or the pointed-to one when both are valid.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        gnt_o[ptr_i] = 1'b1;
      end else begin
        gnt_o = valid_i;
      end
    end
  end

endmodule

// File: rtl/bf16_op_sched.sv
// Schedules commands from two requesters onto one shared bf16 datapath,
// one operation in flight, with per-mode fixed latency and a held response.
module bf16_op_sched
  import data_type_pkg::*;
#(
  parameter int LAT_ADDSUB = 1,
  parameter int LAT_MUL    = 2,
  parameter int LAT_DIV    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][MODE_WIDTH-1:0] req_mode_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_in1_i,
  input  logic [1:0][DATA_WIDTH-1:0] req_in2_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_id_o,
  output logic [DATA_WIDTH-1:0]      rsp_data_o,
  output logic                       rsp_overflow_o,
  output logic [MODE_WIDTH-1:0]      op_mode_o,
  output logic [DATA_WIDTH-1:0]      op_in1_o,
  output logic [DATA_WIDTH-1:0]      op_in2_o,
  input  logic [DATA_WIDTH-1:0]      op_out_i,
  input  logic                       op_overflow_i,
  output logic                       busy_o,
  output logic                       ovf_sticky_o,
  input  logic                       ovf_clr_i
);

  localparam int LAT_MAX_AM = (LAT_ADDSUB > LAT_MUL) ? LAT_ADDSUB : LAT_MUL;
  localparam int LAT_MAX    = (LAT_MAX_AM > LAT_DIV) ? LAT_MAX_AM : LAT_DIV;
  localparam int CNT_W      = $clog2(LAT_MAX) + 1;

  // Remaining EXEC cycles after the first; undefined modes take one cycle.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [MODE_WIDTH-1:0] mode);
    case (mode)
      MODE_ADD, MODE_SUB: return CNT_W'(LAT_ADDSUB - 1);
      MODE_MUL:           return CNT_W'(LAT_MUL - 1);
      MODE_DIV:           return CNT_W'(LAT_DIV - 1);
      default:            return '0;
    endcase
  endfunction

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rr_q, rr_d;
  logic [MODE_WIDTH-1:0] op_mode_q, op_mode_d;
  logic [DATA_WIDTH-1:0] op_in1_q, op_in1_d;
  logic [DATA_WIDTH-1:0] op_in2_q, op_in2_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_ovf_q, rsp_ovf_d;
  logic                  ovf_sticky_q, ovf_sticky_d;

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       capture;
  logic       cur_known;

  rr_arb2 u_arb (
    .en_i   (state_q == IDLE),
    .valid_i(req_valid_i),
    .ptr_i  (rr_q),
    .gnt_o  (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign capture   = (state_q == EXEC) && (cnt_q == '0);
  assign cur_known = mode_known(op_mode_q);

  // The grant is combinational, so it is gated by reset to stay low in reset.
  assign req_ready_o    = gnt & {2{rst_ni}};
  assign rsp_valid_o    = (state_q == RESP);
  assign busy_o         = (state_q != IDLE);
  assign rsp_id_o       = rsp_id_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_overflow_o = rsp_ovf_q;
  assign op_mode_o      = op_mode_q;
  assign op_in1_o       = op_in1_q;
  assign op_in2_o       = op_in2_q;
  assign ovf_sticky_o   = ovf_sticky_q;

  // Next-state logic for the FSM and all datapath-facing registers.
  always_comb begin
    // NOTE: every _d starts from its _q so no branch can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    op_mode_d  = op_mode_q;
    op_in1_d   = op_in1_q;
    op_in2_d   = op_in2_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;

    // A set at the capture edge beats a clear in the same cycle.
    if (capture && cur_known && op_overflow_i) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d   = EXEC;
          op_mode_d = req_mode_i[gnt_idx];
          op_in1_d  = req_in1_i[gnt_idx];
          op_in2_d  = req_in2_i[gnt_idx];
          rsp_id_d  = gnt_idx;
          cnt_d     = lat_m1(req_mode_i[gnt_idx]);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          rsp_data_d = cur_known ? op_out_i : '0;
          rsp_ovf_d  = cur_known & op_overflow_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d   = IDLE;
          rr_d      = ~rsp_id_q;
          op_mode_d = '0;
          op_in1_d  = '0;
          op_in2_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_q         <= 1'b0;
      op_mode_q    <= '0;
      op_in1_q     <= '0;
      op_in2_q     <= '0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      op_mode_q    <= op_mode_d;
      op_in1_q     <= op_in1_d;
      op_in2_q     <= op_in2_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

endmodule

// File: tb/tb_bf16_op_sched.sv
// Scoreboard bench for bf16_op_sched with a behavioural datapath model.
module tb_bf16_op_sched;
  import data_type_pkg::*;

  localparam int LAT_ADDSUB = 1;
  localparam int LAT_MUL    = 2;
  localparam int LAT_DIV    = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][MODE_WIDTH-1:0] req_mode;
  logic [1:0][DATA_WIDTH-1:0] req_in1;
  logic [1:0][DATA_WIDTH-1:0] req_in2;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_ovf;
  logic [MODE_WIDTH-1:0]      op_mode;
  logic [DATA_WIDTH-1:0]      op_in1;
  logic [DATA_WIDTH-1:0]      op_in2;
  logic [DATA_WIDTH-1:0]      op_out;
  logic                       op_ovf;
  logic                       busy;
  logic                       sticky;
  logic                       ovf_clr;

  typedef struct {
    int                    id;
    logic [DATA_WIDTH-1:0] data;
    logic                  ovf;
    int                    due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath; undefined modes return garbage the DUT must mask.
  function automatic logic [DATA_WIDTH-1:0] dp_model(input logic [MODE_WIDTH-1:0] m,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    case (m)
      MODE_ADD: return (a == 16'h3F80 && b == 16'h4000) ? 16'h4040 : a + b;
      MODE_SUB: return a - b;
      MODE_MUL: return a ^ b;
      MODE_DIV: return {b[7:0], a[7:0]};
      default:  return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [MODE_WIDTH-1:0] m,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    if (m > MODE_DIV) return '0;
    return dp_model(m, a, b);
  endfunction

  function automatic int lat_of(input logic [MODE_WIDTH-1:0] m);
    case (m)
      MODE_ADD, MODE_SUB: return LAT_ADDSUB;
      MODE_MUL:           return LAT_MUL;
      MODE_DIV:           return LAT_DIV;
      default:            return 1;
    endcase
  endfunction

  assign op_out = dp_model(op_mode, op_in1, op_in2);

  bf16_op_sched #(
    .LAT_ADDSUB(LAT_ADDSUB),
    .LAT_MUL   (LAT_MUL),
    .LAT_DIV   (LAT_DIV)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_mode_i    (req_mode),
    .req_in1_i     (req_in1),
    .req_in2_i     (req_in2),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_id_o      (rsp_id),
    .rsp_data_o    (rsp_data),
    .rsp_overflow_o(rsp_ovf),
    .op_mode_o     (op_mode),
    .op_in1_o      (op_in1),
    .op_in2_o      (op_in2),
    .op_out_i      (op_out),
    .op_overflow_i (op_ovf),
    .busy_o        (busy),
    .ovf_sticky_o  (sticky),
    .ovf_clr_i     (ovf_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise valid for one requester, wait for its grant, push the expectation.
  task automatic issue(input int id, input logic [MODE_WIDTH-1:0] m,
                       input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                       input logic ovf_exp, output int t, output bit ok);
    req_mode[id]  = m;
    req_in1[id]   = a;
    req_in2[id]   = b;
    req_valid[id] = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
      step();
      #1;
    end
    t = cyc;
    if (ok) sb.push_back('{id, exp_data(m, a, b), ovf_exp, t + 1 + lat_of(m)});
    step();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1; ovf_clr = 1'b0; op_ovf = 1'b0;
    req_mode = '0; req_in1 = '0; req_in2 = '0;
    step(); step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if ({rsp_valid, busy, sticky, rsp_id, rsp_ovf} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 00000", {rsp_valid, busy, sticky, rsp_id, rsp_ovf}); end
    checks++; if ({rsp_data, op_mode, op_in1, op_in2} !== '0) begin errors++;
      $display("FAIL reset_data: got %h want 0", {rsp_data, op_mode, op_in1, op_in2}); end
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    int t; bit ok; exp_t e;
    issue(0, MODE_ADD, 16'h3F80, 16'h4000, 1'b0, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_grant: no grant within budget"); end
    checks++; if ({busy, op_mode, op_in1, op_in2} !== {1'b1, MODE_ADD, 16'h3F80, 16'h4000}) begin errors++;
      $display("FAIL add_issue: got %h want %h", {busy, op_mode, op_in1, op_in2}, {1'b1, MODE_ADD, 16'h3F80, 16'h4000}); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL add_ready_exec: got %b want 00", req_ready); end
    req_valid = 2'b00;
    wait_rsp(ok);
    checks++; if (!ok || sb.size() == 0) begin errors++; $display("FAIL add_rsp: no response within budget"); end
    else begin
      e = sb.pop_front();
      checks++; if (cyc !== e.due) begin errors++; $display("FAIL add_latency: got cycle %0d want %0d", cyc, e.due); end
      checks++; if ({rsp_id, rsp_data, rsp_ovf} !== {e.id[0], e.data, e.ovf}) begin errors++;
        $display("FAIL add_result: got %h want %h", {rsp_id, rsp_data, rsp_ovf}, {e.id[0], e.data, e.ovf}); end
    end
    step();
    checks++; if ({busy, rsp_valid, op_mode, op_in1, op_in2} !== '0) begin errors++;
      $display("FAIL add_idle: got %h want 0", {busy, rsp_valid, op_mode, op_in1, op_in2}); end
  endtask

  task automatic test_div_stall();
    int t; bit ok; exp_t e;
    rsp_ready = 1'b0;
    issue(1, MODE_DIV, 16'h1234, 16'h5678, 1'b0, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL div_grant: no grant within budget"); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_exec: got %b want 1", busy); end
      step();
    end
    checks++; if (!ok || sb.size() == 0) begin errors++; $display("FAIL div_rsp: no response within budget"); end
    else begin
      e = sb.pop_front();
      checks++; if (cyc !== e.due) begin errors++; $display("FAIL div_latency: got cycle %0d want %0d", cyc, e.due); end
      for (int k = 0; k < 5; k++) begin
        checks++; if ({rsp_valid, busy, rsp_id, rsp_data, rsp_ovf} !== {2'b11, e.id[0], e.data, e.ovf}) begin errors++;
          $display("FAIL div_hold: got %h want %h", {rsp_valid, busy, rsp_id, rsp_data, rsp_ovf}, {2'b11, e.id[0], e.data, e.ovf}); end
        step();
      end
    end
    rsp_ready = 1'b1;
    step();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL div_release: got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_back_to_back();
    bit ok; exp_t e; int t; int exp_id; logic rr_model;
    rr_model = 1'b0;
    req_mode = {MODE_MUL, MODE_MUL};
    req_in1 = {16'h0F0F, 16'h1111};
    req_in2 = {16'hAAAA, 16'h5555};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (req_ready != 2'b00) begin ok = 1'b1; break; end
        step(); #1;
      end
      exp_id = int'(rr_model);
      checks++; if (!ok || req_ready !== (rr_model ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL b2b_grant%0d: got %b want id %0d", g, req_ready, exp_id); end
      t = cyc;
      sb.push_back('{exp_id, exp_data(MODE_MUL, req_in1[exp_id], req_in2[exp_id]), 1'b0, t + 1 + LAT_MUL});
      step();
      req_in1[exp_id] = req_in1[exp_id] + 16'h0101;
      wait_rsp(ok);
      checks++; if (!ok || sb.size() == 0) begin errors++; $display("FAIL b2b_rsp%0d: no response within budget", g); end
      else begin
        e = sb.pop_front();
        checks++; if ({rsp_id, rsp_data, cyc} !== {e.id[0], e.data, e.due}) begin errors++;
          $display("FAIL b2b_result%0d: got id %0d data %h cycle %0d want id %0d data %h cycle %0d",
                   g, rsp_id, rsp_data, cyc, e.id, e.data, e.due); end
      end
      rr_model = ~rr_model;
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_overflow();
    int t; bit ok; exp_t e;
    issue(0, MODE_MUL, 16'h4100, 16'h4200, 1'b1, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_grant: no grant within budget"); end
    step();
    op_ovf = 1'b1; ovf_clr = 1'b1;
    step();
    op_ovf = 1'b0; ovf_clr = 1'b0;
    checks++; if (!rsp_valid || sb.size() == 0) begin errors++; $display("FAIL ovf_rsp: got valid %b want 1", rsp_valid); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_data, rsp_ovf, sticky, cyc} !== {e.data, e.ovf, 1'b1, e.due}) begin errors++;
        $display("FAIL ovf_result: got data %h ovf %b sticky %b cycle %0d want %h 1 1 %0d",
                 rsp_data, rsp_ovf, sticky, cyc, e.data, e.due); end
    end
    step();
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky_hold: got %b want 1", sticky); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clr: got %b want 0", sticky); end
  endtask

  task automatic test_undef_mode();
    int t; bit ok; exp_t e;
    op_ovf = 1'b1;
    issue(1, 3'd5, 16'h1111, 16'h2222, 1'b0, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL undef_grant: no grant within budget"); end
    wait_rsp(ok);
    op_ovf = 1'b0;
    checks++; if (!ok || sb.size() == 0) begin errors++; $display("FAIL undef_rsp: no response within budget"); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_id, rsp_data, rsp_ovf, cyc} !== {e.id[0], e.data, e.ovf, e.due}) begin errors++;
        $display("FAIL undef_result: got id %0d data %h ovf %b cycle %0d want %0d %h %b %0d",
                 rsp_id, rsp_data, rsp_ovf, cyc, e.id, e.data, e.ovf, e.due); end
    end
    step();
  endtask

  task automatic test_reset_mid_exec();
    int t; bit ok; bit seen; exp_t e;
    issue(1, MODE_DIV, 16'h3333, 16'h4444, 1'b0, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_grant: no grant within budget"); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, busy, rsp_id, rsp_ovf, rsp_data, op_mode, op_in1, op_in2} !== '0) begin errors++;
      $display("FAIL rst_async: got %h want 0", {req_ready, rsp_valid, busy, rsp_id, rsp_ovf, rsp_data, op_mode, op_in1, op_in2}); end
    sb.delete();
    req_valid = 2'b00;
    step(); step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got valid 1 want 0"); end
    req_mode = {MODE_ADD, MODE_ADD};
    req_in1 = {16'h0100, 16'h0200};
    req_in2 = {16'h0010, 16'h0020};
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_rr: got %b want 01", req_ready); end
    issue(0, MODE_ADD, 16'h0200, 16'h0020, 1'b0, t, ok);
    req_valid = 2'b00;
    wait_rsp(ok);
    checks++; if (!ok || sb.size() == 0) begin errors++; $display("FAIL rst_next_rsp: no response within budget"); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_id, rsp_data, cyc} !== {e.id[0], e.data, e.due}) begin errors++;
        $display("FAIL rst_next_result: got id %0d data %h cycle %0d want %0d %h %0d",
                 rsp_id, rsp_data, cyc, e.id, e.data, e.due); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_div_stall();
    test_back_to_back();
    test_overflow();
    test_undef_mode();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bf16_op_sched.md
BF16_OP_SCHED -- requirements
Module: bf16_op_sched

Interface
REQ-001 SHALL have parameters, one per line:
- LAT_ADDSUB, 1, cycles from operand issue to result capture for MODE_ADD/MODE_SUB.
- LAT_MUL, 2, same for MODE_MUL.
- LAT_DIV, 4, same for MODE_DIV.
- All latencies are ≥1.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports, one per line:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- req_valid_i  in  2  per-requester command valid.
- req_ready_o  out  2  per-requester accept, one-hot or zero.
- req_mode_i  in  2xMODE_WIDTH  per-requester opcode.
- req_in1_i  in  2xDATA_WIDTH  per-requester operand 1.
- req_in2_i  in  2xDATA_WIDTH  per-requester operand 2.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_id_o  out  1  requester index owning the result.
- rsp_data_o  out  DATA_WIDTH  bf16 result.
- rsp_overflow_o  out  1  overflow of this result.
- op_mode_o  out  MODE_WIDTH  mode to the shared op datapath.
- op_in1_o  out  DATA_WIDTH  operand 1 to the datapath.
- op_in2_o  out  DATA_WIDTH  operand 2 to the datapath.
- op_out_i  in  DATA_WIDTH  datapath result.
- op_overflow_i  in  1  datapath overflow.
- busy_o  out  1  high whenever state is not IDLE.
- ovf_sticky_o  out  1  accumulated overflow flag.
- ovf_clr_i  in  1  clears ovf_sticky_o.

Function
REQ-003 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, with one operation outstanding at a time.
REQ-004 In IDLE, req_ready_o SHALL assert combinationally for exactly one valid requester, chosen by a round-robin pointer rr_q.
- Both requesters valid: grant requester rr_q.
- Only one valid: grant that one.
- Outside IDLE: req_ready_o == 0.
REQ-005 On grant (valid&ready at cycle T), the block SHALL:
- register mode, in1, in2 into op_*_o and the requester index into rsp_id_o;
- load cnt = LAT(mode)-1;
- enter EXEC at T+1.
REQ-006 In EXEC, op_*_o SHALL be held stable, and cnt SHALL decrement each cycle.
REQ-007 When cnt == 0 in EXEC, the block SHALL capture op_out_i into rsp_data_o and op_overflow_i into rsp_overflow_o, then enter RESP.
- Net effect: rsp_valid_o rises at T+1+LAT(mode).
REQ-008 In RESP, rsp_valid_o SHALL be 1 and rsp_data_o/rsp_id_o/rsp_overflow_o SHALL hold until rsp_ready_i.
- On rsp_valid_o & rsp_ready_i: go to IDLE, set rr_q = ~rsp_id_o, and clear op_*_o to zero.
- Next grant is possible in the following cycle; there is no same-cycle re-grant.
REQ-009 op_mode_o/op_in1_o/op_in2_o SHALL be zero in IDLE.
REQ-010 A mode value not in {MODE_ADD, MODE_SUB, MODE_MUL, MODE_DIV} SHALL be accepted, use latency 1, and return data 0 with overflow 0.
REQ-011 ovf_sticky_o SHALL set at the capture edge when op_overflow_i=1 and clear on ovf_clr_i.
- Simultaneous set and clear: set wins.
REQ-012 Requester inputs SHALL be ignored outside IDLE; a deasserted req_valid_i while not granted is legal.

Reset
REQ-013 While rst_ni=0, all outputs SHALL be as follows, with cnt=0:
- state IDLE, rr_q=0;
- rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_overflow_o=0;
- op_*_o=0, busy_o=0, ovf_sticky_o=0;
- req_ready_o=0.
REQ-014 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation with no response issued.

Structure
REQ-015 MODE_WIDTH, DATA_WIDTH, MODE_* codes, and an sched_state_e enum (IDLE/EXEC/RESP) SHALL live in data_type_pkg.
REQ-016 A sub-module rr_arb2 (2-way round-robin grant from valid vector and pointer) SHALL be used; latency lookup stays inline.

Verification
REQ-017 Single ADD from req0, in1=0x3F80, in2=0x4000, datapath model gives 0x4040 -> rsp_valid_o at T+2, rsp_id_o=0, rsp_data_o=0x4040.
REQ-018 DIV from req1, rsp_ready_i tied low 5 cycles -> rsp_valid_o at T+5, held stable 5 cycles, rsp_id_o=1, busy_o high throughout.
REQ-019 Both requesters continuously valid with MUL -> grants alternate 0,1,0,1; each response 1+LAT_MUL cycles after its grant.
REQ-020 Model asserts op_overflow_i on a MUL capture while ovf_clr_i=1 in the same cycle -> rsp_overflow_o=1, ovf_sticky_o=1; a later ovf_clr_i alone -> 0.
REQ-021 rst_ni pulsed low during EXEC of a DIV -> all outputs zero immediately, no rsp_valid_o after release, next request served normally with rr_q=0.
REQ-022 Undefined mode code -> response after 2 cycles with data 0 and overflow 0.
